// File: rtl/act_skew_feeder_if.sv
// Upstream vector handshake between an activation source and act_skew_feeder.
interface act_skew_feeder_if #(
  parameter int ROWS = 8,
  parameter int DW   = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [ROWS*DW-1:0]   s_data;
  logic                 s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/act_skew_feeder.sv
// Activation skew feeder for the PE array: row r is delayed by r array steps,
// and each stream is followed by zero-padded flush steps so its last vector
// fully traverses the skew.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no stream in progress; accepts the first vector of a stream
// STREAM | stream in progress; steps only on an accepted vector
// FLUSH  | ROWS-1 zero-padded steps, upstream held off
module act_skew_feeder #(
  parameter int ROWS = 8,
  parameter int DW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  act_skew_feeder_if.slave           s,
  output logic [0:ROWS-1][DW-1:0]    out_a,
  output logic                       fire,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam int FCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FCW-1:0] FLUSH_LEN = FCW'(ROWS - 1);
  localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);

  state_t         state_q;
  logic [FCW-1:0] fcnt_q;
  logic           fire_q;
  logic           acc;
  logic           adv;

  assign s.s_ready = (state_q != FLUSH);
  assign acc       = s.s_valid & s.s_ready;
  assign adv       = acc | (state_q == FLUSH);
  assign fire      = fire_q;
  assign busy      = (state_q != IDLE);

  // Stream sequencing, flush length counter and the registered step strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      fire_q  <= 1'b0;
    end else begin
      fire_q <= adv;
      case (state_q)
        IDLE, STREAM: begin
          if (acc) begin
            if (!s.s_last) begin
              state_q <= STREAM;
            end else if (ROWS > 1) begin
              state_q <= FLUSH;
              fcnt_q  <= FLUSH_LEN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          fcnt_q <= fcnt_q - FCNT_ONE;
          if (fcnt_q == FCNT_ONE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] dl_q [r+1];

    // Row r shift line of r+1 stages; zeros are injected while flushing.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) dl_q[k] <= '0;
      end else if (adv) begin
        dl_q[0] <= (state_q == FLUSH) ? '0 : s.s_data[r*DW +: DW];
        for (int k = 1; k <= r; k++) dl_q[k] <= dl_q[k-1];
      end
    end

    assign out_a[r] = dl_q[r];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder (ROWS=8 main instance, ROWS=1 build).
module tb_act_skew_feeder;
  localparam int ROWS = 8;
  localparam int DW   = 8;

  typedef logic [0:ROWS-1][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) s8 ();
  vec_t out_a8;
  logic fire8, busy8;
  act_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .s(s8), .out_a(out_a8), .fire(fire8), .busy(busy8));

  act_skew_feeder_if #(.ROWS(1), .DW(DW)) s1 ();
  logic [0:0][DW-1:0] out_a1;
  logic fire1, busy1;
  act_skew_feeder #(.ROWS(1), .DW(DW)) dut1 (
    .clk(clk), .rst(rst), .s(s1), .out_a(out_a1), .fire(fire1), .busy(busy1));

  vec_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int fire_cnt, run_len, max_run, nready0, busy_cnt;
  int f1cnt, f1busy, f1nready;
  logic [DW-1:0] f1val;
  vec_t prev_out;
  logic prev_rst = 1'b1;
  vec_t popped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected out_a per fire pulse: row r at pulse p carries vector p-r of the stream.
  task automatic push_exp(input vec_t vals[$], input int npulses);
    vec_t e;
    int n = vals.size();
    for (int p = 1; p <= npulses; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        int idx = p - r;
        e[r] = (idx >= 1 && idx <= n) ? vals[idx-1][r] : '0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input vec_t v, input logic last);
    int budget = 50;
    s8.s_valid = 1'b1;
    s8.s_last  = last;
    for (int r = 0; r < ROWS; r++) s8.s_data[r*DW +: DW] = v[r];
    @(negedge clk);
    while (!s8.s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: s_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    s8.s_valid = 1'b0;
    s8.s_last  = 1'b0;
    s8.s_data  = '0;
  endtask

  task automatic clear_counters();
    fire_cnt = 0; run_len = 0; max_run = 0; nready0 = 0; busy_cnt = 0;
  endtask

  task automatic wait_idle();
    int budget = 100;
    @(negedge clk);
    while (busy8 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy stayed 1, required 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic vec_t fill(input int val);
    vec_t v;
    for (int r = 0; r < ROWS; r++) v[r] = DW'(val);
    return v;
  endfunction

  // Monitor: scoreboard pop on fire, hold check on stalls, activity counters.
  always @(negedge clk) begin
    if (fire8 === 1'b1) begin
      fire_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_fire: got out_a %h with no expected entry", out_a8);
      end else begin
        popped = exp_q.pop_front();
        check("out_a_at_fire", out_a8, popped);
      end
    end else begin
      run_len = 0;
      if (!prev_rst) check("out_a_hold", out_a8, prev_out);
    end
    if (!s8.s_ready) nready0++;
    if (busy8) busy_cnt++;
    prev_out = out_a8;
    prev_rst = rst;
  end

  // Activity monitor for the ROWS=1 build.
  always @(negedge clk) begin
    if (!rst) begin
      if (fire1 === 1'b1) begin
        f1cnt++;
        f1val = out_a1[0];
      end
      if (busy1) f1busy++;
      if (!s1.s_ready) f1nready++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vals[$];
    vec_t v;
    s8.s_valid = 1'b0; s8.s_last = 1'b0; s8.s_data = '0;
    s1.s_valid = 1'b0; s1.s_last = 1'b0; s1.s_data = '0;
    f1cnt = 0; f1busy = 0; f1nready = 0; f1val = '0;
    clear_counters();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_out_a", out_a8, '0);
    check("reset_fire", fire8, 0);
    check("reset_busy", busy8, 0);
    check("reset_s_ready", s8.s_ready, 1);

    // Single vector {r+1}
    clear_counters();
    for (int r = 0; r < ROWS; r++) v[r] = DW'(r + 1);
    vals = {v};
    push_exp(vals, 8);
    send(v, 1'b1);
    wait_idle();
    check("single_fire_cnt", fire_cnt, 8);
    check("single_fire_run", max_run, 8);
    check("single_busy_cycles", busy_cnt, 7);
    check("single_ready_low", nready0, 7);

    // Ten back-to-back vectors
    clear_counters();
    vals = {};
    for (int k = 1; k <= 10; k++) vals.push_back(fill(k));
    push_exp(vals, 17);
    for (int k = 1; k <= 10; k++) send(fill(k), k == 10);
    wait_idle();
    check("ten_fire_cnt", fire_cnt, 17);
    check("ten_fire_run", max_run, 17);
    check("ten_busy_cycles", busy_cnt, 16);

    // Same stream with a gap after every vector
    clear_counters();
    push_exp(vals, 17);
    for (int k = 1; k <= 10; k++) begin
      send(fill(k), k == 10);
      if (k != 10) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("gap_fire_cnt", fire_cnt, 17);
    check("gap_fire_run", max_run, 8);

    // Two 3-vector streams back to back
    clear_counters();
    vals = {fill(1), fill(2), fill(3)};
    push_exp(vals, 10);
    vals = {fill(4), fill(5), fill(6)};
    push_exp(vals, 10);
    for (int k = 1; k <= 6; k++) send(fill(k), k == 3 || k == 6);
    wait_idle();
    check("b2b_fire_cnt", fire_cnt, 20);
    check("b2b_fire_run", max_run, 20);
    check("b2b_ready_low", nready0, 14);

    // Reset after the fourth accepted vector
    clear_counters();
    vals = {fill(1), fill(2), fill(3), fill(4)};
    push_exp(vals, 4);
    for (int k = 1; k <= 4; k++) send(fill(k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_a", out_a8, '0);
    check("midrst_fire", fire8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_s_ready", s8.s_ready, 1);
    check("midrst_pulses_before", fire_cnt, 4);

    clear_counters();
    for (int r = 0; r < ROWS; r++) v[r] = DW'(r + 1);
    vals = {v};
    push_exp(vals, 8);
    send(v, 1'b1);
    wait_idle();
    check("postrst_fire_cnt", fire_cnt, 8);
    check("postrst_fire_run", max_run, 8);
    check("postrst_busy_cycles", busy_cnt, 7);

    // ROWS=1 build
    f1cnt = 0; f1busy = 0; f1nready = 0;
    s1.s_valid = 1'b1; s1.s_last = 1'b1; s1.s_data = 8'hA5;
    @(posedge clk); #1;
    s1.s_valid = 1'b0; s1.s_last = 1'b0; s1.s_data = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rows1_fire_cnt", f1cnt, 1);
    check("rows1_out_a", f1val, 8'hA5);
    check("rows1_busy_cycles", f1busy, 0);
    check("rows1_ready_low", f1nready, 0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
